// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with optional return-address stack.
//
// Holds the current word address and selects the next one from PLUS4,
// BRANCH, JUMP, JR, CALL and RET.
// Misaligned jump-register targets redirect to EXC_PC and raise addr_err
// for one cycle.
// Define PC_GEN_RAS_EN to build in the circular return-address stack.
// Without it, CALL acts as JUMP and RET acts as JR.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   stall    1 = hold pc, stack, ras_cnt and addr_err
//   npc_op   next-PC select (PLUS4/BRANCH/JUMP/JR/CALL/RET)
//   imm      [15:0] branch word offset, [25:0] jump word index
//   rs_val   jump-register byte address
//   pc       current word address (registered)
//   npc      next word address (combinational)
//   addr_err one-cycle pulse after a misaligned JR/RET target (registered)
//   ras_cnt  valid stack entries (0 when the stack is not built)
module pc_gen #(
    parameter int unsigned AW        = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic [2:0]                     npc_op,
    input  logic [25:0]                    imm,
    input  logic [AW-1:0]                  rs_val,
    output logic [AW-3:0]                  pc,
    output logic [AW-3:0]                  npc,
    output logic                           addr_err,
    output logic [$clog2(RAS_DEPTH):0]     ras_cnt
);

    localparam int unsigned PW   = AW - 2;
    localparam int unsigned CW   = $clog2(RAS_DEPTH) + 1;

    localparam logic [2:0] OP_PLUS4  = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JR     = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;

    // Bits of the word address replaced by the jump index
    localparam logic [PW-1:0] IMM_MASK = PW'(26'h3FF_FFFF);

    logic [PW-1:0] p1;
    logic [PW-1:0] br_tgt;
    logic [PW-1:0] jmp_tgt;
    logic [PW-1:0] jr_tgt;
    logic          use_rs;
    logic          misalign;

`ifdef PC_GEN_RAS_EN
    localparam int unsigned PTRW = $clog2(RAS_DEPTH);

    logic [PW-1:0]   ras_mem [RAS_DEPTH];
    logic [PTRW-1:0] ras_ptr;       // next free slot; top is ras_ptr-1
    logic [PW-1:0]   ras_top;
    logic            push;
    logic            pop;

    assign ras_top = ras_mem[ras_ptr - PTRW'(1)];
`endif

    // Next-PC selection
    always_comb begin
        p1      = pc + PW'(1);
        br_tgt  = p1 + {{(PW-16){imm[15]}}, imm[15:0]};
        jmp_tgt = (p1 & ~IMM_MASK) | PW'(imm);
        jr_tgt  = rs_val[AW-1:2];
        npc     = p1;
        use_rs  = 1'b0;
`ifdef PC_GEN_RAS_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (npc_op)
            OP_PLUS4:  npc = p1;
            OP_BRANCH: npc = br_tgt;
            OP_JUMP:   npc = jmp_tgt;
            OP_JR: begin
                npc    = jr_tgt;
                use_rs = 1'b1;
            end
            OP_CALL: begin
                npc = jmp_tgt;
`ifdef PC_GEN_RAS_EN
                push = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef PC_GEN_RAS_EN
                if (ras_cnt != CW'(0)) begin
                    npc = ras_top;
                    pop = 1'b1;
                end else begin
                    npc    = jr_tgt;
                    use_rs = 1'b1;
                end
`else
                npc    = jr_tgt;
                use_rs = 1'b1;
`endif
            end
            default:   npc = p1;
        endcase
        misalign = use_rs && (rs_val[1:0] != 2'b00);
    end

    // PC and error pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC[AW-1:2];
            addr_err <= 1'b0;
        end else if (!stall) begin
            if (misalign) begin
                pc       <= EXC_PC[AW-1:2];
                addr_err <= 1'b1;
            end else begin
                pc       <= npc;
                addr_err <= 1'b0;
            end
        end
    end

`ifdef PC_GEN_RAS_EN
    // Stack pointer and occupancy; a full push overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (!stall) begin
            if (push) begin
                ras_ptr <= ras_ptr + PTRW'(1);
                if (ras_cnt != CW'(RAS_DEPTH)) begin
                    ras_cnt <= ras_cnt + CW'(1);
                end
            end else if (pop) begin
                ras_ptr <= ras_ptr - PTRW'(1);
                ras_cnt <= ras_cnt - CW'(1);
            end
        end
    end

    // Stack storage, no reset needed
    always_ff @(posedge clk) begin
        if (rst && !stall && push) begin
            ras_mem[ras_ptr] <= p1;
        end
    end
`else
    assign ras_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table vectors, hand sequences and randomized checking of pc_gen
// against a queue-based reference model.
module tb_pc_gen;

    localparam int unsigned AW = 32;
    localparam longint MOD     = 64'h4000_0000;
    localparam longint JSPAN   = 64'h0400_0000;
    localparam longint RST_W   = 64'h0C00;
    localparam longint EXC_W   = 64'h1060;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  npc_op;
    logic [25:0] imm;
    logic [31:0] rs_val;
    logic [29:0] pc;
    logic [29:0] npc;
    logic        addr_err;
    logic [2:0]  ras_cnt;

    int nvec = 0;
    int nerr = 0;

    pc_gen dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .npc_op   (npc_op),
        .imm      (imm),
        .rs_val   (rs_val),
        .pc       (pc),
        .npc      (npc),
        .addr_err (addr_err),
        .ras_cnt  (ras_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    longint m_pc;
    bit     m_err;
    longint m_stk[$];

    function automatic bit ras_on();
`ifdef PC_GEN_RAS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_uses_rs(input logic [2:0] op);
        return (op == 3'd3) || (op == 3'd5 && !(ras_on() && m_stk.size() > 0));
    endfunction

    function automatic longint m_npc(input logic [2:0] op, input logic [25:0] im,
                                     input logic [31:0] rs);
        longint p1;
        longint off;
        p1  = (m_pc + 1) % MOD;
        off = im[15] ? longint'(im[15:0]) - 65536 : longint'(im[15:0]);
        case (op)
            3'd1: return (p1 + off + MOD) % MOD;
            3'd2, 3'd4: return (p1 / JSPAN) * JSPAN + longint'(im);
            3'd3: return longint'(rs) / 4;
            3'd5: begin
                if (ras_on() && m_stk.size() > 0) return m_stk[$];
                return longint'(rs) / 4;
            end
            default: return p1;
        endcase
    endfunction

    task automatic m_step(input bit r, input bit s, input logic [2:0] op,
                          input logic [25:0] im, input logic [31:0] rs);
        longint n;
        longint p1;
        bit     ur;
        if (!r) begin
            m_pc  = RST_W;
            m_err = 1'b0;
            m_stk.delete();
        end else if (!s) begin
            n  = m_npc(op, im, rs);
            ur = m_uses_rs(op);
            p1 = (m_pc + 1) % MOD;
            if (ras_on() && op == 3'd4) begin
                m_stk.push_back(p1);
                if (m_stk.size() > 4) void'(m_stk.pop_front());
            end else if (ras_on() && op == 3'd5 && m_stk.size() > 0) begin
                void'(m_stk.pop_back());
            end
            if (ur && rs[1:0] != 2'b00) begin
                m_pc  = EXC_W;
                m_err = 1'b1;
            end else begin
                m_pc  = n;
                m_err = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one cycle; model follows; outputs settle #1 after the edge
    task automatic cyc(input bit r, input bit s, input logic [2:0] op,
                       input logic [25:0] im, input logic [31:0] rs, input bit chk_npc);
        @(negedge clk);
        rst = r; stall = s; npc_op = op; imm = im; rs_val = rs;
        #1;
        if (chk_npc && r) chk("npc", 64'(npc), 64'(m_npc(op, im, rs)));
        @(posedge clk);
        m_step(r, s, op, im, rs);
        #1;
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  op;
        logic [25:0] im;
        logic [31:0] rs;
        logic [29:0] epc;
        bit          eerr;
    } vec_t;

    vec_t tv[24];

    initial begin
        logic [29:0] ret_pc [5];
        logic [2:0]  call_cnt [5];
        logic [2:0]  ret_cnt [5];
        logic [2:0]  op;
        bit          r;
        bit          s;
        logic [31:0] rs;

        tv[0]  = '{0, 3'd0, 26'h0,       32'h0,          30'h0C01,     0};
        tv[1]  = '{0, 3'd0, 26'h0,       32'h0,          30'h0C02,     0};
        tv[2]  = '{0, 3'd0, 26'h0,       32'h0,          30'h0C03,     0};
        tv[3]  = '{0, 3'd3, 26'h0,       32'h0000_3040,  30'h0C10,     0};
        tv[4]  = '{0, 3'd1, 26'hFFFE,    32'h0,          30'h0C0F,     0};
        tv[5]  = '{0, 3'd3, 26'h0,       32'h0000_3002,  30'h1060,     1};
        tv[6]  = '{0, 3'd0, 26'h0,       32'h0,          30'h1061,     0};
        tv[7]  = '{0, 3'd3, 26'h0,       32'h0000_3008,  30'h0C02,     0};
        tv[8]  = '{1, 3'd2, 26'h100,     32'h0,          30'h0C02,     0};
        tv[9]  = '{1, 3'd2, 26'h100,     32'h0,          30'h0C02,     0};
        tv[10] = '{0, 3'd2, 26'h100,     32'h0,          30'h0000100,  0};
        tv[11] = '{0, 3'd3, 26'h0,       32'hFFFF_FFFC,  30'h3FFFFFFF, 0};
        tv[12] = '{0, 3'd0, 26'h0,       32'h0,          30'h0,        0};
        tv[13] = '{0, 3'd1, 26'hFFFE,    32'h0,          30'h3FFFFFFF, 0};
        tv[14] = '{1, 3'd3, 26'h0,       32'h0000_3001,  30'h3FFFFFFF, 0};
        tv[15] = '{0, 3'd6, 26'h0,       32'h0,          30'h0,        0};
        tv[16] = '{0, 3'd7, 26'h0,       32'h0,          30'h1,        0};
        tv[17] = '{0, 3'd3, 26'h0,       32'h0FFF_FFFC,  30'h03FFFFFF, 0};
        tv[18] = '{0, 3'd2, 26'h5,       32'h0,          30'h04000005, 0};
        tv[19] = '{0, 3'd3, 26'h0,       32'h0000_3003,  30'h1060,     1};
        tv[20] = '{1, 3'd0, 26'h0,       32'h0,          30'h1060,     1};
        tv[21] = '{0, 3'd0, 26'h0,       32'h0,          30'h1061,     0};
        tv[22] = '{0, 3'd1, 26'h7FFF,    32'h0,          30'h9061,     0};
        tv[23] = '{0, 3'd1, 26'h3FF8000, 32'h0,          30'h1062,     0};

        rst = 1'b0; stall = 1'b0; npc_op = 3'd0; imm = '0; rs_val = '0;

        // Reset state
        cyc(0, 0, 3'd0, 26'h0, 32'h0, 0);
        cyc(0, 0, 3'd0, 26'h0, 32'h0, 0);
        chk("reset_pc", 64'(pc), 64'h0C00);
        chk("reset_err", 64'(addr_err), 64'h0);
        chk("reset_cnt", 64'(ras_cnt), 64'h0);

        // Directed table
        foreach (tv[i]) begin
            cyc(1, tv[i].st, tv[i].op, tv[i].im, tv[i].rs, 1);
            chk($sformatf("tv%0d_pc", i), 64'(pc), 64'(tv[i].epc));
            chk($sformatf("tv%0d_err", i), 64'(addr_err), 64'(tv[i].eerr));
        end

        // Reset wins over a CALL in the same cycle
        cyc(1, 0, 3'd4, 26'h10, 32'h0, 1);
        chk("call_cnt", 64'(ras_cnt), ras_on() ? 64'h1 : 64'h0);
        cyc(0, 0, 3'd4, 26'h20, 32'h0, 0);
        chk("rstcall_pc", 64'(pc), 64'h0C00);
        chk("rstcall_cnt", 64'(ras_cnt), 64'h0);

        // Reset wins over stall and clears a pending error pulse
        cyc(1, 0, 3'd3, 26'h0, 32'h0000_3001, 1);
        chk("pre_rst_err", 64'(addr_err), 64'h1);
        cyc(0, 1, 3'd3, 26'h0, 32'h0000_3008, 0);
        chk("rststall_pc", 64'(pc), 64'h0C00);
        chk("rststall_err", 64'(addr_err), 64'h0);
        cyc(1, 0, 3'd0, 26'h0, 32'h0, 1);
        chk("post_rst_pc", 64'(pc), 64'h0C01);

        // Five CALLs then five RETs, last one on an empty stack
        ret_pc   = ras_on() ? '{30'h501, 30'h401, 30'h301, 30'h201, 30'h800}
                            : '{30'h800, 30'h800, 30'h800, 30'h800, 30'h800};
        call_cnt = ras_on() ? '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4} : '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        ret_cnt  = ras_on() ? '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0} : '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        cyc(1, 0, 3'd3, 26'h0, 32'h0000_0400, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 3'd4, 26'(32'h200 + 32'(k) * 32'h100), 32'h0, 1);
            chk($sformatf("call%0d_pc", k), 64'(pc), 64'(32'h200 + 32'(k) * 32'h100));
            chk($sformatf("call%0d_cnt", k), 64'(ras_cnt), 64'(call_cnt[k]));
        end
        cyc(1, 1, 3'd5, 26'h0, 32'h0000_2000, 1);
        chk("stall_ret_pc", 64'(pc), 64'h600);
        chk("stall_ret_cnt", 64'(ras_cnt), 64'(call_cnt[4]));
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 3'd5, 26'h0, 32'h0000_2000, 1);
            chk($sformatf("ret%0d_pc", k), 64'(pc), 64'(ret_pc[k]));
            chk($sformatf("ret%0d_cnt", k), 64'(ras_cnt), 64'(ret_cnt[k]));
        end
        cyc(1, 0, 3'd5, 26'h0, 32'h0000_2002, 1);
        chk("ret_empty_mis_pc", 64'(pc), 64'h1060);
        chk("ret_empty_mis_err", 64'(addr_err), 64'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 99) < 15);
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = 3'd4;
            if ($urandom_range(0, 3) == 0) op = 3'd5;
            rs = $urandom();
            if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
            cyc(r, s, op, 26'($urandom()), rs, 1);
            chk("rnd_pc", 64'(pc), 64'(m_pc));
            chk("rnd_err", 64'(addr_err), 64'(m_err));
            chk("rnd_cnt", 64'(ras_cnt), 64'(m_stk.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter AW, default 32, PC byte-address width; legal range 28..32.
REQ-002 Parameter RESET_PC, default 32'h0000_3000, byte address loaded on reset; bits [1:0] are ignored.
REQ-003 Parameter EXC_PC, default 32'h0000_4180, byte address loaded on a misaligned jump-register target.
REQ-004 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; power of two, 2..16.
REQ-005 clk  input  1  rising-edge clock, the only clock.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 stall  input  1  1 = hold PC and stack this cycle.
REQ-008 npc_op  input  3  next-PC select: 000 PLUS4, 001 BRANCH, 010 JUMP, 011 JR, 100 CALL, 101 RET; 110/111 reserved.
REQ-009 imm  input  26  offset field; [15:0] is the branch word offset, [25:0] is the jump word index.
REQ-010 rs_val  input  AW  jump-register byte address.
REQ-011 pc  output  AW-2  current word address, PC[AW-1:2], registered.
REQ-012 npc  output  AW-2  next word address, combinational from pc, npc_op, imm, rs_val and stack state.
REQ-013 addr_err  output  1  registered one-cycle pulse on a misaligned JR/RET target.
REQ-014 ras_cnt  output  log2(RAS_DEPTH)+1  valid stack entries; constant 0 when RAS_EN is undefined.

Function
REQ-015 PLUS4: npc = pc+1, modulo 2^(AW-2).
REQ-016 BRANCH: npc = pc+1+sign-extend(imm[15:0]) to AW-2 bits, wrapping modulo 2^(AW-2).
REQ-017 JUMP: npc = {p1[AW-3:26], imm[25:0]}, where p1 = pc+1.
REQ-018 JR: npc = rs_val[AW-1:2].
REQ-019 Reserved codes: npc = pc+1; npc is fully assigned for every code, so no latch is inferred.
REQ-020 On each rising clk with rst=1 and stall=0, pc loads npc, except on a misaligned target (REQ-021).
REQ-021 Misaligned target: JR (or RET falling back to rs_val) with rs_val[1:0]!=0 loads pc with EXC_PC[AW-1:2] and sets addr_err=1 for the next cycle.
REQ-022 addr_err is 0 in every other cycle.
REQ-023 stall=1: pc, stack contents, ras_cnt and addr_err hold their values; npc still tracks its inputs.
REQ-024 Single-cycle latency: the op presented in cycle N is reflected on pc in cycle N+1.

Reset
REQ-025 rst=0 at a rising clk: pc = RESET_PC[AW-1:2], addr_err = 0, ras_cnt = 0, stack pointer = 0; stack entries are don't-care.
REQ-026 Reset has priority over stall and over any op in the same cycle.
REQ-027 After rst rises, the first non-stalled edge executes npc_op normally.

Configuration
REQ-028 Macro PC_GEN_RAS_EN compiles in the return-address stack.
REQ-029 With PC_GEN_RAS_EN, CALL: npc per JUMP; on a non-stalled edge, push pc+1 and increment ras_cnt.
REQ-030 With PC_GEN_RAS_EN, pushing when ras_cnt = RAS_DEPTH overwrites the oldest entry (circular pointer) and ras_cnt stays at RAS_DEPTH.
REQ-031 With PC_GEN_RAS_EN, RET with ras_cnt>0: npc = top entry; on a non-stalled edge, pop and decrement ras_cnt. The REQ-021 alignment check does not apply.
REQ-032 With PC_GEN_RAS_EN, RET with ras_cnt=0 behaves exactly as JR, including the REQ-021 check.
REQ-033 Without PC_GEN_RAS_EN, CALL behaves as JUMP and RET behaves as JR; no stack storage is instantiated.

Verification
REQ-034 Reset, then 3 non-stalled PLUS4 cycles -> pc = 0xC00, 0xC01, 0xC02, 0xC03 (byte addresses 0x3000..0x300C).
REQ-035 pc=0xC10, BRANCH with imm[15:0]=16'hFFFE -> next pc = 0xC0F; repeat at pc=0x3FFFFFFF with PLUS4 -> pc wraps to 0.
REQ-036 JR with rs_val=0x0000_3002 -> pc = 0x1060 (EXC_PC>>2), addr_err high for exactly one cycle; JR with rs_val=0x0000_3008 -> pc = 0xC02, addr_err = 0.
REQ-037 stall=1 for 2 cycles during JUMP imm=26'h0000100 -> pc unchanged; the first cycle after stall drops loads pc = 0x0000100 (upper bits from pc+1).
REQ-038 PC_GEN_RAS_EN, RAS_DEPTH=4: 5 CALLs from pc=A..E, then 5 RETs -> targets E+1, D+1, C+1, B+1, then rs_val (empty stack), with ras_cnt 4,3,2,1,0,0.
REQ-039 rst=0 asserted in the same cycle as CALL -> pc = 0xC00, ras_cnt = 0, no push.
